// File: rtl/quad_lane_merge.sv
// Four-lane to one-lane merge: per-lane FIFOs drained round-robin into a registered valid/ready output.
// Optional even-parity output port enabled by defining QUAD_LANE_MERGE_PARITY_EN.
module quad_lane_merge #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            in_valid,
    output logic [3:0]            in_ready,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_lane
`ifdef QUAD_LANE_MERGE_PARITY_EN
    ,
    output logic                  out_parity
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    // Handshake: a word moves on any rising edge where valid and ready are both high.
    logic [DATA_W-1:0] mem [4][FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr [4];
    logic [AW-1:0]     rd_ptr [4];
    logic [AW:0]       count [4];

    logic [1:0]        rr;
    logic [1:0]        grant;
    logic [1:0]        scan_idx;
    logic [3:0]        non_empty;
    logic [3:0]        push;
    logic [3:0]        pop;
    logic              load;
    logic [DATA_W-1:0] head;

    always_comb begin
        non_empty = '0;
        in_ready  = '0;
        push      = '0;
        for (int i = 0; i < 4; i++) begin
            non_empty[i] = (count[i] != '0);
            in_ready[i]  = rst_n && (count[i] < DEPTH_C);
            push[i]      = in_valid[i] && in_ready[i];
        end
    end

    // Scan from the farthest offset back to rr so the closest non-empty lane wins.
    always_comb begin
        grant    = rr;
        scan_idx = rr;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = rr + 2'(k);
            if (non_empty[scan_idx]) begin
                grant = scan_idx;
            end
        end
    end

    assign load = (!out_valid || out_ready) && (|non_empty);
    assign head = mem[grant][rd_ptr[grant]];

    always_comb begin
        pop = '0;
        for (int i = 0; i < 4; i++) begin
            pop[i] = load && (grant == 2'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            rr        <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= head;
            out_lane  <= grant;
            rr        <= grant + 2'd1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef QUAD_LANE_MERGE_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (load) begin
            out_parity <= ^head;
        end
    end
`endif

endmodule
